pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

- Parametrised pipeline stage register with a ready/valid handshake, a two-entry skid buffer, synchronous flush and a saturating stall counter.
- Replaces hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the five-stage core.
- Payload is split into a control field, which is squashed on flush or bubble, and a data field, which is never squashed.
- Sits between a producing stage and a consuming stage. It gives one-cycle latency, full throughput, and no combinational path from `out_ready` to `in_ready`.

## Interface
Parameters:
- `CTRL_W`, default 8: control-field width (RegDst, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, …).
- `DATA_W`, default 111: data-field width (register indices, immediate, operand values).
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous squash of stage contents.
- `in_valid` in 1: producer has a beat.
- `in_ready` out 1: stage can accept a beat.
- `in_ctrl` in `CTRL_W`: control field of incoming beat.
- `in_data` in `DATA_W`: data field of incoming beat.
- `out_valid` out 1: stage holds a valid beat.
- `out_ready` in 1: consumer accepts the beat.
- `out_ctrl` out `CTRL_W`: control field; forced to 0 when `out_valid`=0.
- `out_data` out `DATA_W`: data field of the current head entry.
- `stall_cnt` out `CNT_W`: saturating count of back-pressure cycles.
- `cnt_clr` in 1: synchronous clear of `stall_cnt`.

## Operation
- Storage: main entry (`m_ctrl`, `m_data`) drives the outputs; skid entry (`s_ctrl`, `s_data`) holds overflow.
- Handshake signals:
  - `in_fire` = `in_valid` & `in_ready`.
  - `out_fire` = `out_valid` & `out_ready`.
- Decode from state:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
  - Both are decoded from registers only.
- State machine and transitions:
  - EMPTY: `in_fire` → ONE, main <= in. Otherwise stay.
  - ONE, `in_fire` & `out_fire` → ONE, main <= in.
  - ONE, `in_fire` & !`out_fire` → FULL, skid <= in.
  - ONE, !`in_fire` & `out_fire` → EMPTY.
  - ONE, neither → hold.
  - FULL, `out_fire` → ONE, main <= skid. `in_ready` is 0, so no capture.
  - FULL, !`out_fire` → hold.
- Ordering: strict FIFO. A skid beat always leaves before any later input.
- Flush (priority over every transition):
  - Next state is EMPTY.
  - `m_ctrl` and `s_ctrl` <= 0.
  - `m_data` and `s_data` hold their values.
  - An `in_fire` in the flush cycle is discarded.
  - An `out_fire` in the flush cycle still counts as consumed downstream.
- `out_ctrl` = `out_valid` ? `m_ctrl` : 0. A bubble therefore never carries asserted control bits.
- Stall counter:
  - `cnt_clr` → 0 (priority over increment).
  - Otherwise +1 when `out_valid` & !`out_ready` & !`flush`.
  - Saturates at 2^`CNT_W`−1; never wraps.

## Timing
- Reset (`rst_n`=0, takes effect immediately, no clock needed):
  - State EMPTY; all entries 0; `stall_cnt`=0.
  - `out_valid`=0, `out_ctrl`=0, `out_data`=0.
  - `in_ready`=1, but no beat is captured while `rst_n` is low.
  - First capture possible on the first rising edge after `rst_n` deasserts.
- Reset asserted mid-operation: the contents of both entries are lost, with no partial transfer.
- Latency: a beat accepted at edge N is presented on `out_*` right after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` falls one cycle after the first unaccepted capture into ONE (entry into FULL).
- `in_ready` rises the cycle after the FULL → ONE drain.
- Simultaneous `flush` & `cnt_clr`: both apply.
- `flush` while FULL: both entries are squashed, and `in_ready`=1 the next cycle.

## Test plan
- Streaming: `out_ready`=1, push ctrl 0x01..0x05 with data 1..5 back-to-back. Required:
  - Outputs appear one cycle later, in order.
  - `in_ready` stays 1.
  - `stall_cnt` stays 0.
- Skid fill: send A (ctrl 0x11), then B (ctrl 0x22) while `out_ready`=0. Required:
  - `in_ready`=0 after B is taken.
  - `out_ctrl` stays 0x11 while stalled.
  - Raising `out_ready` yields A then B on consecutive cycles.
  - `in_ready` returns to 1.
- Flush: flush while FULL with `in_valid`=1 (ctrl 0xFF). Required:
  - Next cycle `out_valid`=0 and `out_ctrl`=0.
  - The 0xFF beat is dropped.
  - `out_data` retains the old head value.
  - The next push appears normally.
- Stall counter: hold `out_valid`=1 with `out_ready`=0 for 10 cycles. Required:
  - `stall_cnt`=10.
  - Pulsing `cnt_clr` gives `stall_cnt`=0 next cycle.
  - With `CNT_W`=3 and 20 stall cycles, `stall_cnt`=7.
- Async reset: drop `rst_n` between clock edges while FULL. Required:
  - Immediately `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0.
  - After release, a single push of ctrl 0x3C appears one cycle later.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: ready/valid handshake, two-entry skid buffer,
// synchronous flush that squashes only the control field, saturating stall counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 111,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_r, state_s;
  logic [CTRL_W-1:0] m_ctrl_r, m_ctrl_s, s_ctrl_r, s_ctrl_s;
  logic [DATA_W-1:0] m_data_r, m_data_s, s_data_r, s_data_s;
  logic [CNT_W-1:0]  stall_cnt_r, stall_cnt_s;
  logic              in_ready_s, out_valid_s, in_fire_s, out_fire_s;

  // Handshake flags come straight from the state register, so out_ready never reaches in_ready.
  assign in_ready_s  = (state_r != ST_FULL);
  assign out_valid_s = (state_r != ST_EMPTY);
  assign in_fire_s   = in_valid & in_ready_s;
  assign out_fire_s  = out_valid_s & out_ready;

  // Next-state and entry updates; flush overrides every handshake transition.
  always_comb begin
    state_s  = state_r;
    m_ctrl_s = m_ctrl_r;
    m_data_s = m_data_r;
    s_ctrl_s = s_ctrl_r;
    s_data_s = s_data_r;
    if (flush) begin
      state_s  = ST_EMPTY;
      m_ctrl_s = {CTRL_W{1'b0}};
      s_ctrl_s = {CTRL_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_s  = ST_ONE;
            m_ctrl_s = in_ctrl;
            m_data_s = in_data;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_s  = ST_ONE;
            m_ctrl_s = in_ctrl;
            m_data_s = in_data;
          end else if (in_fire_s) begin
            state_s  = ST_FULL;
            s_ctrl_s = in_ctrl;
            s_data_s = in_data;
          end else if (out_fire_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_s  = ST_ONE;
            m_ctrl_s = s_ctrl_r;
            m_data_s = s_data_r;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Back-pressure counter: clear wins, flush cycles are not counted, never wraps.
  always_comb begin
    stall_cnt_s = stall_cnt_r;
    if (cnt_clr) begin
      stall_cnt_s = {CNT_W{1'b0}};
    end else if (out_valid_s && !out_ready && !flush && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_s = stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // State, storage and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      m_ctrl_r    <= {CTRL_W{1'b0}};
      m_data_r    <= {DATA_W{1'b0}};
      s_ctrl_r    <= {CTRL_W{1'b0}};
      s_data_r    <= {DATA_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      m_ctrl_r    <= m_ctrl_s;
      m_data_r    <= m_data_s;
      s_ctrl_r    <= s_ctrl_s;
      s_data_r    <= s_data_s;
      stall_cnt_r <= stall_cnt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_ctrl  = out_valid_s ? m_ctrl_r : {CTRL_W{1'b0}};
  assign out_data  = m_data_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// traffic against a queue-based model of a two-deep FIFO stage.
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] in_ctrl = 8'h00;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [15:0]   stall_cnt;
  logic          in_ready3, out_valid3;
  logic [CW-1:0] out_ctrl3;
  logic [DW-1:0] out_data3;
  logic [2:0]    stall_cnt3;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] m_held = '0;
  int unsigned   cnt16 = 0;
  int unsigned   cnt3 = 0;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
  );

  pipe_stage_reg #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready3),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready),
    .out_ctrl(out_ctrl3), .out_data(out_data3), .stall_cnt(stall_cnt3), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  // One clock edge; the model advances using the inputs presented before the edge.
  task automatic step();
    logic  iv, orr, fl, clr, inr, ov, rst_low;
    beat_t b;
    rst_low = !rst_n;
    iv  = in_valid;
    orr = out_ready;
    fl  = flush;
    clr = cnt_clr;
    b.c = in_ctrl;
    b.d = in_data;
    inr = (q.size() < 2);
    ov  = (q.size() > 0);
    @(posedge clk);
    #1;
    if (rst_low) begin
      q.delete();
      m_held = '0;
      cnt16  = 0;
      cnt3   = 0;
    end else begin
      if (clr) begin
        cnt16 = 0;
        cnt3  = 0;
      end else if (ov && !orr && !fl) begin
        if (cnt16 < 65535) cnt16 = cnt16 + 1;
        if (cnt3 < 7) cnt3 = cnt3 + 1;
      end
      if (fl) begin
        q.delete();
      end else begin
        if (ov && orr) void'(q.pop_front());
        if (iv && inr) q.push_back(b);
      end
      if (q.size() > 0) m_held = q[0].d;
    end
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({out_valid, in_ready, out_ctrl, stall_cnt} !== {1'b0, 1'b1, 8'h00, 16'h0000}) begin
      fails++;
      $display("FAIL reset_flags: got v=%b r=%b c=%h cnt=%0d want v=0 r=1 c=00 cnt=0",
               out_valid, in_ready, out_ctrl, stall_cnt);
    end
    tests++;
    if (out_data !== {DW{1'b0}}) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", out_data);
    end
    in_valid = 1'b1; in_ctrl = 8'hA5;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_capture: got out_valid=%b want 0", out_valid);
    end
    #2;
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 8'(i);
      in_data  = DW'(i);
      step();
      tests++;
      if ({out_valid, out_ctrl, out_data, in_ready, stall_cnt} !==
          {1'b1, 8'(i), DW'(i), 1'b1, 16'h0000}) begin
        fails++;
        $display("FAIL stream_beat%0d: got v=%b c=%h d=%0h r=%b cnt=%0d want v=1 c=%h d=%0h r=1 cnt=0",
                 i, out_valid, out_ctrl, out_data, in_ready, stall_cnt, 8'(i), i);
      end
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_skid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h11; in_data = DW'(16'hAAAA);
    step();
    in_ctrl = 8'h22; in_data = DW'(16'hBBBB);
    step();
    tests++;
    if ({in_ready, out_ctrl} !== {1'b0, 8'h11}) begin
      fails++;
      $display("FAIL skid_full: got r=%b c=%h want r=0 c=11", in_ready, out_ctrl);
    end
    in_valid = 1'b0;
    step();
    step();
    tests++;
    if ({in_ready, out_valid, out_ctrl, out_data} !== {1'b0, 1'b1, 8'h11, DW'(16'hAAAA)}) begin
      fails++;
      $display("FAIL skid_hold: got r=%b v=%b c=%h d=%0h want r=0 v=1 c=11 d=aaaa",
               in_ready, out_valid, out_ctrl, out_data);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if ({in_ready, out_valid, out_ctrl, out_data} !== {1'b1, 1'b1, 8'h22, DW'(16'hBBBB)}) begin
      fails++;
      $display("FAIL skid_drain_b: got r=%b v=%b c=%h d=%0h want r=1 v=1 c=22 d=bbbb",
               in_ready, out_valid, out_ctrl, out_data);
    end
    step();
    tests++;
    if ({in_ready, out_valid, out_ctrl} !== {1'b1, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL skid_empty: got r=%b v=%b c=%h want r=1 v=0 c=00", in_ready, out_valid, out_ctrl);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'h33; in_data = DW'(16'h1234);
    step();
    in_ctrl = 8'h44; in_data = DW'(16'h5678);
    step();
    flush = 1'b1; in_ctrl = 8'hFF; in_data = DW'(16'hFFFF);
    step();
    tests++;
    if ({out_valid, out_ctrl, in_ready, out_data} !== {1'b0, 8'h00, 1'b1, DW'(16'h1234)}) begin
      fails++;
      $display("FAIL flush_full: got v=%b c=%h r=%b d=%0h want v=0 c=00 r=1 d=1234",
               out_valid, out_ctrl, in_ready, out_data);
    end
    flush = 1'b0; in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_drop: got out_valid=%b want 0", out_valid);
    end
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = DW'(16'h0F0F); out_ready = 1'b1;
    step();
    tests++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h5A, DW'(16'h0F0F)}) begin
      fails++;
      $display("FAIL flush_next_push: got v=%b c=%h d=%0h want v=1 c=5a d=f0f", out_valid, out_ctrl, out_data);
    end
    idle();
    step();
  endtask

  task automatic test_stall_counter();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'h01; in_data = DW'(1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    tests++;
    if (stall_cnt !== 16'd10) begin
      fails++;
      $display("FAIL stall_10: got %0d want 10", stall_cnt);
    end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    tests++;
    if ({stall_cnt, stall_cnt3} !== {16'd0, 3'd0}) begin
      fails++;
      $display("FAIL stall_clr: got %0d/%0d want 0/0", stall_cnt, stall_cnt3);
    end
    for (int i = 0; i < 20; i++) step();
    tests++;
    if ({stall_cnt, stall_cnt3} !== {16'd20, 3'd7}) begin
      fails++;
      $display("FAIL stall_sat: got %0d/%0d want 20/7", stall_cnt, stall_cnt3);
    end
    flush = 1'b1; cnt_clr = 1'b1;
    step();
    tests++;
    if ({out_valid, stall_cnt} !== {1'b0, 16'd0}) begin
      fails++;
      $display("FAIL flush_and_clr: got v=%b cnt=%0d want v=0 cnt=0", out_valid, stall_cnt);
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_ctrl = 8'h77; in_data = DW'(16'hCAFE);
    step();
    in_ctrl = 8'h88;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_ctrl, out_data, stall_cnt} !== {1'b0, 8'h00, {DW{1'b0}}, 16'd0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b c=%h d=%0h cnt=%0d want all 0", out_valid, out_ctrl, out_data, stall_cnt);
    end
    in_valid = 1'b1; in_ctrl = 8'h99;
    step();
    #2;
    rst_n = 1'b1;
    in_ctrl = 8'h3C; in_data = DW'(16'h003C);
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    tests++;
    if ({out_valid, out_ctrl, out_data, in_ready} !== {1'b1, 8'h3C, DW'(16'h003C), 1'b1}) begin
      fails++;
      $display("FAIL async_after: got v=%b c=%h d=%0h r=%b want v=1 c=3c d=3c r=1",
               out_valid, out_ctrl, out_data, in_ready);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_single: got out_valid=%b want 0", out_valid);
    end
    idle();
  endtask

  task automatic test_random();
    logic          exp_v, exp_r;
    logic [CW-1:0] exp_c;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      in_ctrl   = 8'($urandom);
      in_data   = DW'({$urandom, $urandom, $urandom, $urandom});
      step();
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2);
      exp_c = exp_v ? q[0].c : 8'h00;
      tests++;
      if ({out_valid, in_ready, out_ctrl, out_data, stall_cnt, stall_cnt3} !==
          {exp_v, exp_r, exp_c, m_held, 16'(cnt16), 3'(cnt3)}) begin
        fails++;
        $display("FAIL random_cyc%0d: got v=%b r=%b c=%h d=%h cnt=%0d/%0d want v=%b r=%b c=%h d=%h cnt=%0d/%0d",
                 i, out_valid, in_ready, out_ctrl, out_data, stall_cnt, stall_cnt3,
                 exp_v, exp_r, exp_c, m_held, cnt16, cnt3);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_stall_counter();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
